// File: rtl/fp_mult_pkg.sv
// ============================================================================
// Module      : fp_mult_pkg
// Description : Shared types and constants for the custom-format FP
//               multiplier (sign | ES-bit exponent | M-bit fraction).
//               Constants are derived from (N, ES) through functions so that
//               every parameterisation of the datapath uses one definition.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_mult_pkg;

    // Fraction width
    function automatic int fp_m(input int n, input int es);
        return n - 1 - es;
    endfunction

    // Exponent bias, 2^(ES-1)-1
    function automatic int fp_bias(input int es);
        return (1 << (es - 1)) - 1;
    endfunction

    // All-ones exponent (inf / NaN encoding)
    function automatic int fp_exp_max(input int es);
        return (1 << es) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all-ones, fraction MSB set.
    // Returned 64 bits wide; callers keep the low N bits.
    function automatic logic [63:0] fp_qnan(input int n, input int es);
        logic [63:0] v;
        v = (((64'd1 << es) - 64'd1) << (n - 1 - es)) | (64'd1 << (n - 2 - es));
        return v;
    endfunction

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    // Flag vector bit positions: {invalid, overflow, underflow, inexact}
    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

endpackage

`default_nettype wire

// File: rtl/fp_round_pack.sv
// ============================================================================
// Module      : fp_round_pack
// Description : Combinational round + pack for a normalised significand.
//               Applies RNE/RTZ, handles rounding carry-out, saturates to
//               inf / max-finite on overflow, flushes to zero on underflow,
//               and passes pre-decoded special results straight through.
// Ports       : i_sign/i_exp/i_frac  normalised result (exp signed, ES+2 b)
//               i_guard/i_sticky     bits below the fraction LSB
//               i_rnd_mode           0 = RNE, 1 = RTZ
//               i_spec/i_spec_word/i_spec_inv  special-case bypass
//               o_r/o_flags          packed word, {inv, ovf, unf, inx}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_pack
    import fp_mult_pkg::*;
#(
    parameter int N  = 24,
    parameter int ES = 6
) (
    input  logic            i_sign,
    input  logic [ES+1:0]   i_exp,
    input  logic [N-ES-2:0] i_frac,
    input  logic            i_guard,
    input  logic            i_sticky,
    input  logic            i_rnd_mode,
    input  logic            i_spec,
    input  logic [N-1:0]    i_spec_word,
    input  logic            i_spec_inv,
    output logic [N-1:0]    o_r,
    output logic [3:0]      o_flags
);

    localparam int M = fp_m(N, ES);
    localparam logic signed [ES+1:0] c_EXP_MAX = (ES+2)'(fp_exp_max(ES));

    logic                 w_inc;
    logic [M:0]           w_sum;
    logic signed [ES+1:0] w_exp_r;
    logic                 w_ovf;
    logic                 w_unf;

    always_comb begin
        w_inc   = !i_rnd_mode && i_guard && (i_sticky || i_frac[0]);
        w_sum   = {1'b0, i_frac} + {{M{1'b0}}, w_inc};
        // A carry out of the fraction means 1.11..1 rounded up to 10.00..0:
        // the fraction is already zero, only the exponent moves.
        w_exp_r = $signed(i_exp) + $signed({{(ES+1){1'b0}}, w_sum[M]});
        w_ovf   = (w_exp_r >= c_EXP_MAX);
        w_unf   = w_exp_r[ES+1] || (w_exp_r == '0);

        o_r     = {i_sign, w_exp_r[ES-1:0], w_sum[M-1:0]};
        o_flags = '0;
        if (i_spec) begin
            o_r              = i_spec_word;
            o_flags[FLG_INV] = i_spec_inv;
        end else if (w_ovf) begin
            o_r              = i_rnd_mode ? {i_sign, {(ES-1){1'b1}}, 1'b0, {M{1'b1}}}
                                          : {i_sign, {ES{1'b1}}, {M{1'b0}}};
            o_flags[FLG_OVF] = 1'b1;
            o_flags[FLG_INX] = 1'b1;
        end else if (w_unf) begin
            o_r              = {i_sign, {(N-1){1'b0}}};
            o_flags[FLG_UNF] = 1'b1;
            o_flags[FLG_INX] = 1'b1;
        end else begin
            o_flags[FLG_INX] = i_guard || i_sticky;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_mult_pipe.sv
// ============================================================================
// Module      : fp_mult_pipe
// Description : Three-stage pipelined custom-format FP multiplier with
//               valid/ready handshake and full backpressure.
//               S1: decode + significand multiply, S2: normalise,
//               S3: round + pack (fp_round_pack). The whole pipe advances
//               together whenever the output register can accept data.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready, a, b, rnd_mode   operand side
//               out_valid/out_ready, r, flags       result side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter int N  = 24,
    parameter int ES = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         rnd_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] r,
    output logic [3:0]   flags
);

    localparam int M = fp_m(N, ES);
    localparam logic [ES+1:0] c_BIAS     = (ES+2)'(fp_bias(ES));
    localparam logic [63:0]   c_QNAN_64  = fp_qnan(N, ES);
    localparam logic [N-1:0]  c_QNAN     = c_QNAN_64[N-1:0];

    function automatic fp_class_e classify(input logic [ES-1:0] e, input logic [M-1:0] f);
        if (e == '0)               return CLS_ZERO;
        else if (e != {ES{1'b1}})  return CLS_NORM;
        else if (f == '0)          return CLS_INF;
        else                       return CLS_NAN;
    endfunction

    // ---------------- Stage 1: decode + multiply ----------------
    fp_class_e        w_ca, w_cb;
    logic             w_sign1;
    logic [ES+1:0]    w_exp1;
    logic [2*M+1:0]   w_prod1;
    logic             w_spec1;
    logic             w_inv1;
    logic [N-1:0]     w_word1;

    always_comb begin
        w_ca    = classify(a[N-2 -: ES], a[M-1:0]);
        w_cb    = classify(b[N-2 -: ES], b[M-1:0]);
        w_sign1 = a[N-1] ^ b[N-1];
        w_exp1  = {2'b00, a[N-2 -: ES]} + {2'b00, b[N-2 -: ES]} - c_BIAS;
        w_prod1 = {{(M+1){1'b0}}, 1'b1, a[M-1:0]} * {{(M+1){1'b0}}, 1'b1, b[M-1:0]};

        w_spec1 = 1'b1;
        w_inv1  = 1'b0;
        w_word1 = c_QNAN;
        if ((w_ca == CLS_ZERO && w_cb == CLS_INF) || (w_ca == CLS_INF && w_cb == CLS_ZERO)) begin
            w_inv1 = 1'b1;
        end else if (w_ca == CLS_NAN || w_cb == CLS_NAN) begin
            w_word1 = c_QNAN;
        end else if (w_ca == CLS_INF || w_cb == CLS_INF) begin
            w_word1 = {w_sign1, {ES{1'b1}}, {M{1'b0}}};
        end else if (w_ca == CLS_ZERO || w_cb == CLS_ZERO) begin
            w_word1 = {w_sign1, {(N-1){1'b0}}};
        end else begin
            w_spec1 = 1'b0;
        end
    end

    logic             r_v1, r_v2, r_v3;
    logic             r_sign1, r_rnd1, r_spec1, r_inv1;
    logic [ES+1:0]    r_exp1;
    logic [2*M+1:0]   r_prod1;
    logic [N-1:0]     r_word1;

    // ---------------- Stage 2: normalise ----------------
    logic             w_msb2;
    logic [ES+1:0]    w_exp2;
    logic [M-1:0]     w_frac2;
    logic             w_guard2;
    logic             w_sticky2;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); MSB set means >= 2.
        w_msb2    = r_prod1[2*M+1];
        w_exp2    = r_exp1 + {{(ES+1){1'b0}}, w_msb2};
        w_frac2   = w_msb2 ? r_prod1[2*M:M+1] : r_prod1[2*M-1:M];
        w_guard2  = w_msb2 ? r_prod1[M]       : r_prod1[M-1];
        w_sticky2 = w_msb2 ? |r_prod1[M-1:0]  : |r_prod1[M-2:0];
    end

    logic             r_sign2, r_rnd2, r_spec2, r_inv2, r_guard2, r_sticky2;
    logic [ES+1:0]    r_exp2;
    logic [M-1:0]     r_frac2;
    logic [N-1:0]     r_word2;

    // ---------------- Stage 3: round + pack ----------------
    logic [N-1:0]     w_r3;
    logic [3:0]       w_flags3;
    logic [N-1:0]     r_r3;
    logic [3:0]       r_flags3;

    fp_round_pack #(.N(N), .ES(ES)) u_round_pack (
        .i_sign      (r_sign2),
        .i_exp       (r_exp2),
        .i_frac      (r_frac2),
        .i_guard     (r_guard2),
        .i_sticky    (r_sticky2),
        .i_rnd_mode  (r_rnd2),
        .i_spec      (r_spec2),
        .i_spec_word (r_word2),
        .i_spec_inv  (r_inv2),
        .o_r         (w_r3),
        .o_flags     (w_flags3)
    );

    // ---------------- Handshake + pipeline registers ----------------
    assign in_ready  = !r_v3 || out_ready;
    assign out_valid = r_v3;
    assign r         = r_r3;
    assign flags     = r_flags3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
            r_sign1 <= 1'b0; r_rnd1 <= 1'b0; r_spec1 <= 1'b0; r_inv1 <= 1'b0;
            r_exp1 <= '0; r_prod1 <= '0; r_word1 <= '0;
            r_sign2 <= 1'b0; r_rnd2 <= 1'b0; r_spec2 <= 1'b0; r_inv2 <= 1'b0;
            r_guard2 <= 1'b0; r_sticky2 <= 1'b0;
            r_exp2 <= '0; r_frac2 <= '0; r_word2 <= '0;
            r_r3 <= '0; r_flags3 <= '0;
        end else if (in_ready) begin
            r_v1      <= in_valid;
            r_sign1   <= w_sign1;
            r_rnd1    <= rnd_mode;
            r_spec1   <= w_spec1;
            r_inv1    <= w_inv1;
            r_exp1    <= w_exp1;
            r_prod1   <= w_prod1;
            r_word1   <= w_word1;

            r_v2      <= r_v1;
            r_sign2   <= r_sign1;
            r_rnd2    <= r_rnd1;
            r_spec2   <= r_spec1;
            r_inv2    <= r_inv1;
            r_guard2  <= w_guard2;
            r_sticky2 <= w_sticky2;
            r_exp2    <= w_exp2;
            r_frac2   <= w_frac2;
            r_word2   <= r_word1;

            r_v3      <= r_v2;
            r_r3      <= w_r3;
            r_flags3  <= w_flags3;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
// ============================================================================
// Module      : tb_fp_mult_pipe
// Description : Self-checking bench for fp_mult_pipe (N=24, ES=6).
//               Expected results are queued at operand transfer and compared
//               at result transfer; a reference model covers random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a, b;
    logic        rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] r;
    logic [3:0]  flags;

    fp_mult_pipe #(.N(24), .ES(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rnd_mode  (rnd_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] r;
        logic [3:0]  f;
        int          cyc;
        logic        lat;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          n_out  = 0;
    logic [23:0] t_er;
    logic [3:0]  t_ef;
    logic        t_lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Independent reference: exact integer product, rounded by comparing the
    // discarded remainder against one half ULP.
    function automatic logic [27:0] model(input logic [23:0] x, input logic [23:0] y, input logic rm);
        int              ex, ey, e, L, sh;
        logic            s, xz, yz, xi, yi, xn, yn;
        longint unsigned P, kept, rem, half;
        logic [3:0]      f;
        s  = x[23] ^ y[23];
        ex = int'(x[22:17]);
        ey = int'(y[22:17]);
        xz = (ex == 0); yz = (ey == 0);
        xi = (ex == 63) && (x[16:0] == 0); yi = (ey == 63) && (y[16:0] == 0);
        xn = (ex == 63) && (x[16:0] != 0); yn = (ey == 63) && (y[16:0] != 0);
        if ((xz && yi) || (xi && yz)) return {4'b1000, 24'h7F0000};
        if (xn || yn)                 return {4'b0000, 24'h7F0000};
        if (xi || yi)                 return {4'b0000, s, 23'h7E0000};
        if (xz || yz)                 return {4'b0000, s, 23'h000000};
        P = (64'(x[16:0]) | (64'd1 << 17)) * (64'(y[16:0]) | (64'd1 << 17));
        L = 0;
        for (int i = 0; i < 40; i++) if (P[i]) L = i;
        e    = ex + ey - 31 + (L - 34);
        sh   = L - 17;
        kept = P >> sh;
        rem  = P & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        f    = {3'b000, rem != 0};
        if (!rm && (rem > half || (rem == half && kept[0]))) kept++;
        if (kept == (64'd1 << 18)) begin kept = kept >> 1; e++; end
        if (e >= 63) return {4'b0101, s, rm ? 23'h7DFFFF : 23'h7E0000};
        if (e <= 0)  return {4'b0011, s, 23'h000000};
        return {f, s, 6'(e), kept[16:0]};
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: decisions for the coming edge are taken mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sb.push_back('{r: t_er, f: t_ef, cyc: cyc, lat: t_lat});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("r[%0d]", n_out), 32'(r), 32'(e.r));
                    chk($sformatf("flags[%0d]", n_out), 32'(flags), 32'(e.f));
                    if (e.lat) chk($sformatf("latency[%0d]", n_out), 32'(cyc - e.cyc), 32'd3);
                    n_out++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the operand transfer.
    task automatic send(input logic [23:0] ta, input logic [23:0] tb, input logic trm,
                        input logic [23:0] er, input logic [3:0] ef, input logic lat);
        int t;
        in_valid = 1'b1; a = ta; b = tb; rnd_mode = trm;
        t_er = er; t_ef = ef; t_lat = lat;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [23:0] ta, input logic [23:0] tb, input logic trm);
        logic [27:0] m;
        m = model(ta, tb, trm);
        send(ta, tb, trm, m[23:0], m[27:24], 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin @(negedge clk); t++; end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [23:0] rand_op();
        return {1'($urandom), 6'($urandom_range(25, 37)), 17'($urandom)};
    endfunction

    logic [23:0] da [11] = '{24'h3F0000, 24'h400000, 24'h3E0001, 24'h3E0001, 24'h7C0000, 24'h7C0000,
                             24'h000000, 24'h7E0000, 24'h020000, 24'h7E0001, 24'h800000};
    logic [23:0] db [11] = '{24'h3F0000, 24'hBF0000, 24'h3F0000, 24'h3F0000, 24'h7C0000, 24'h7C0000,
                             24'h7E0000, 24'hBE0000, 24'h020000, 24'h3F0000, 24'h3F0000};
    logic        dm [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [23:0] dr [11] = '{24'h404000, 24'hC10000, 24'h3F0002, 24'h3F0001, 24'h7E0000, 24'h7DFFFF,
                             24'h7F0000, 24'hFE0000, 24'h000000, 24'h7F0000, 24'h800000};
    logic [3:0]  df [11] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0101,
                             4'b1000, 4'b0000, 4'b0011, 4'b0000, 4'b0000};

    initial begin
        logic [23:0] snap;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; rnd_mode = 1'b0; out_ready = 1'b1;
        t_er = '0; t_ef = '0; t_lat = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed cases, issued back-to-back with no output stall
        for (int i = 0; i < 11; i++) send(da[i], db[i], dm[i], dr[i], df[i], 1'b1);
        drain();

        // Six back-to-back ops with a 4-cycle output stall in the middle
        fork
            begin
                for (int i = 0; i < 6; i++) send_model(rand_op(), rand_op(), 1'($urandom));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                snap = r;
                repeat (3) @(negedge clk);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                chk("stall_r_hold", 32'(r), 32'(snap));
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", 32'(n_out), 32'd17);

        // Reset in the middle of a stream: in-flight work is dropped
        for (int i = 0; i < 3; i++) send_model(rand_op(), rand_op(), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_r", 32'(r), 32'd0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("postrst_out_valid", 32'(out_valid), 32'd0);
        chk("postrst_count", 32'(n_out), 32'd17);
        @(posedge clk); #1;

        // Post-reset traffic resumes normally
        send(24'h3F0000, 24'h3F0000, 1'b0, 24'h404000, 4'b0000, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
